// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard slot, forwarding select
// and the source-vs-slot match used by both the stall and forwarding logic.
package pipe_pkg;

  // Register addresses are carried zero-extended to this width inside the scoreboard.
  localparam int unsigned MaxRegAw = 8;

  typedef logic [MaxRegAw-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      wr;
    logic      ld;
  } sb_slot_t;

  // x0 is hard-wired zero, so it never produces a hazard.
  function automatic logic slot_match(sb_slot_t slot, reg_addr_t src, logic use_src);
    return slot.valid & slot.wr & (slot.rd != '0) & (slot.rd == src) & use_src;
  endfunction

  function automatic fwd_sel_t fwd_pick(logic ex_hit, logic mem_hit);
    if (ex_hit) return FWD_EXMEM;
    if (mem_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, stall and forwarding controller for the 5-stage core. Tracks in-flight
// destinations in an EX/MEM/WB scoreboard and drives enables, flushes and forwarding.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              de_valid_i,
  input  logic [REG_AW-1:0] de_rs1_i,
  input  logic [REG_AW-1:0] de_rs2_i,
  input  logic              de_use_rs1_i,
  input  logic              de_use_rs2_i,
  input  logic [REG_AW-1:0] de_rd_i,
  input  logic              de_reg_write_i,
  input  logic              de_mem_read_i,
  input  logic              ex_br_taken_i,
  input  logic              mem_ready_i,
  output logic              pc_en_o,
  output logic              fe_de_en_o,
  output logic              fe_de_flush_o,
  output logic              de_ex_flush_o,
  output logic              ex_mem_en_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  sb_slot_t  ex_q, mem_q, wb_q, ex_d;
  fwd_sel_t  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  reg_addr_t rs1, rs2, rd;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic stall_fwd, stall_int, stall, branch;
  logic stall_inc, flush_inc;

  assign rs1 = reg_addr_t'(de_rs1_i);
  assign rs2 = reg_addr_t'(de_rs2_i);
  assign rd  = reg_addr_t'(de_rd_i);

  assign ex_hit1  = slot_match(ex_q, rs1, de_use_rs1_i);
  assign ex_hit2  = slot_match(ex_q, rs2, de_use_rs2_i);
  assign mem_hit1 = slot_match(mem_q, rs1, de_use_rs1_i);
  assign mem_hit2 = slot_match(mem_q, rs2, de_use_rs2_i);
  assign wb_hit1  = slot_match(wb_q, rs1, de_use_rs1_i);
  assign wb_hit2  = slot_match(wb_q, rs2, de_use_rs2_i);

  // With forwarding only a load still in EX is too late; without it every
  // in-flight producer must drain through WB first.
  assign stall_fwd = ex_q.ld & (ex_hit1 | ex_hit2);
  assign stall_int = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2 | wb_hit1 | wb_hit2;
  assign stall     = de_valid_i & (FWD_EN ? stall_fwd : stall_int);

  // A frozen pipeline ignores the branch; EX re-presents it once memory is ready.
  assign branch    = mem_ready_i & ex_br_taken_i;
  assign stall_inc = mem_ready_i & ~ex_br_taken_i & stall;
  assign flush_inc = branch;

  always_comb begin
    pc_en_o       = 1'b1;
    fe_de_en_o    = 1'b1;
    fe_de_flush_o = 1'b0;
    de_ex_flush_o = 1'b0;
    ex_mem_en_o   = 1'b1;
    if (!rst_ni) begin
      // Defaults hold while reset is asserted regardless of other inputs.
    end else if (!mem_ready_i) begin
      pc_en_o     = 1'b0;
      fe_de_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
    end else if (branch) begin
      fe_de_flush_o = 1'b1;
      de_ex_flush_o = 1'b1;
    end else if (stall) begin
      pc_en_o       = 1'b0;
      fe_de_en_o    = 1'b0;
      de_ex_flush_o = 1'b1;
    end
  end

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!branch && !stall && de_valid_i) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = rd;
      ex_d.wr    = de_reg_write_i;
      ex_d.ld    = de_mem_read_i;
      if (FWD_EN) begin
        fwd_a_d = fwd_pick(ex_hit1, mem_hit1);
        fwd_b_d = fwd_pick(ex_hit2, mem_hit2);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (mem_ready_i) begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (stall_inc),
    .clr_i (1'b0),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (flush_inc),
    .clr_i (1'b0),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench: a forwarding build and a stall-only build with narrow counters
// share one stimulus stream; each scenario task checks its own expectations.
module tb_pipe_hazard_unit;

  logic       clk, rst_n;
  logic       de_valid, de_use_rs1, de_use_rs2, de_reg_write, de_mem_read;
  logic [4:0] de_rs1, de_rs2, de_rd;
  logic       ex_br_taken, mem_ready;

  logic        pc_en, fe_de_en, fe_de_flush, de_ex_flush, ex_mem_en;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic        so_pc_en, so_fe_de_en, so_fe_de_flush, so_de_ex_flush, so_ex_mem_en;
  logic [1:0]  so_fwd_a, so_fwd_b;
  logic [1:0]  so_stall_cnt, so_flush_cnt;

  logic [4:0] ctrl;
  assign ctrl = {pc_en, fe_de_en, fe_de_flush, de_ex_flush, ex_mem_en};

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .de_valid_i(de_valid), .de_rs1_i(de_rs1),
    .de_rs2_i(de_rs2), .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2),
    .de_rd_i(de_rd), .de_reg_write_i(de_reg_write), .de_mem_read_i(de_mem_read),
    .ex_br_taken_i(ex_br_taken), .mem_ready_i(mem_ready), .pc_en_o(pc_en),
    .fe_de_en_o(fe_de_en), .fe_de_flush_o(fe_de_flush), .de_ex_flush_o(de_ex_flush),
    .ex_mem_en_o(ex_mem_en), .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(2)) u_so (
    .clk_i(clk), .rst_ni(rst_n), .de_valid_i(de_valid), .de_rs1_i(de_rs1),
    .de_rs2_i(de_rs2), .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2),
    .de_rd_i(de_rd), .de_reg_write_i(de_reg_write), .de_mem_read_i(de_mem_read),
    .ex_br_taken_i(ex_br_taken), .mem_ready_i(mem_ready), .pc_en_o(so_pc_en),
    .fe_de_en_o(so_fe_de_en), .fe_de_flush_o(so_fe_de_flush),
    .de_ex_flush_o(so_de_ex_flush), .ex_mem_en_o(so_ex_mem_en), .fwd_a_sel_o(so_fwd_a),
    .fwd_b_sel_o(so_fwd_b), .stall_cnt_o(so_stall_cnt), .flush_cnt_o(so_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic set_de(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    de_valid = v; de_rs1 = rs1; de_rs2 = rs2; de_use_rs1 = u1; de_use_rs2 = u2;
    de_rd = rd; de_reg_write = wr; de_mem_read = ld;
  endtask

  task automatic set_idle();
    set_de(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_br_taken = 1'b0;
    mem_ready   = 1'b1;
  endtask

  // Inputs change at posedge+1 and are sampled from there, clear of both edges.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    ex_br_taken = 1'b1;
    mem_ready   = 1'b0;
    #2;
    n_checks++;
    if (ctrl !== 5'b11001) $display("FAIL reset_ctrl: got %b required %b", ctrl, 5'b11001);
    else n_pass++;
    n_checks++;
    if ({fwd_a, fwd_b, stall_cnt, flush_cnt} !== '0)
      $display("FAIL reset_state: got fwd %0d/%0d cnt %0d/%0d required all 0",
               fwd_a, fwd_b, stall_cnt, flush_cnt);
    else n_pass++;
    step();
    set_idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fwd_ex();
    do_reset();
    set_de(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5,x1,x2
    step();
    set_de(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // sub x6,x5,x1
    #1;
    n_checks++;
    if (ctrl !== 5'b11001) $display("FAIL fwd_ex_nostall: got %b required %b", ctrl, 5'b11001);
    else n_pass++;
    step();
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b0100)
      $display("FAIL fwd_ex_sel: got a=%0d b=%0d required a=1 b=0", fwd_a, fwd_b);
    else n_pass++;
  endtask

  task automatic test_fwd_mem();
    do_reset();
    set_de(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5
    step();
    set_de(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);  // nop
    step();
    set_de(1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);  // or x7,x0,x5
    step();
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b0010)
      $display("FAIL fwd_mem_sel: got a=%0d b=%0d required a=0 b=2", fwd_a, fwd_b);
    else n_pass++;
  endtask

  task automatic test_x0();
    do_reset();
    set_de(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1);  // lw x0
    step();
    set_de(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add x3,x0,x0
    #1;
    n_checks++;
    if (ctrl !== 5'b11001) $display("FAIL x0_nostall: got %b required %b", ctrl, 5'b11001);
    else n_pass++;
    step();
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b0000)
      $display("FAIL x0_fwd: got a=%0d b=%0d required a=0 b=0", fwd_a, fwd_b);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_de(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);  // lw x8
    step();
    set_de(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);  // add x9,x8,x8
    #1;
    n_checks++;
    if (ctrl !== 5'b00011) $display("FAIL load_use_stall: got %b required %b", ctrl, 5'b00011);
    else n_pass++;
    step();
    n_checks++;
    if (ctrl !== 5'b11001) $display("FAIL load_use_release: got %b required %b", ctrl, 5'b11001);
    else n_pass++;
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b0000)
      $display("FAIL load_use_bubble_fwd: got a=%0d b=%0d required 0/0", fwd_a, fwd_b);
    else n_pass++;
    step();
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b1010)
      $display("FAIL load_use_fwd: got a=%0d b=%0d required a=2 b=2", fwd_a, fwd_b);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 32'd1) $display("FAIL load_use_cnt: got %0d required 1", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_stall_only();
    do_reset();
    set_de(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5
    step();
    set_de(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // dependent on x5
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({so_pc_en, so_de_ex_flush, so_fwd_a, so_fwd_b} !== 6'b010000)
        $display("FAIL stall_only_cycle%0d: got pc_en=%b flush=%b fwd=%0d/%0d required 0 1 0/0",
                 i, so_pc_en, so_de_ex_flush, so_fwd_a, so_fwd_b);
      else n_pass++;
      step();
    end
    n_checks++;
    if (so_pc_en !== 1'b1) $display("FAIL stall_only_release: got %b required 1", so_pc_en);
    else n_pass++;
    step();
    n_checks++;
    if ({so_stall_cnt, so_fwd_a, so_fwd_b} !== 6'b110000)
      $display("FAIL stall_only_cnt: got cnt=%0d fwd=%0d/%0d required 3 0/0",
               so_stall_cnt, so_fwd_a, so_fwd_b);
    else n_pass++;
  endtask

  // Narrow counter of the stall-only build must pin at all-ones.
  task automatic test_saturate();
    set_de(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // add x10
    step();
    set_de(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (so_stall_cnt !== 2'd3) $display("FAIL saturate: got %0d required 3", so_stall_cnt);
    else n_pass++;
  endtask

  task automatic test_branch_load_use();
    do_reset();
    set_de(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);  // lw x8
    step();
    set_de(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    ex_br_taken = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 5'b11111) $display("FAIL branch_prio: got %b required %b", ctrl, 5'b11111);
    else n_pass++;
    step();
    set_idle();
    n_checks++;
    if ({flush_cnt, stall_cnt} !== {32'd1, 32'd0})
      $display("FAIL branch_cnt: got flush=%0d stall=%0d required 1 0", flush_cnt, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_freeze_reset();
    do_reset();
    ex_br_taken = 1'b1;
    step();
    ex_br_taken = 1'b0;
    set_de(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);  // lw x8
    step();
    set_de(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    step();
    step();
    set_de(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    mem_ready   = 1'b0;
    ex_br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ctrl !== 5'b00000) $display("FAIL freeze_ctrl%0d: got %b required 00000", i, ctrl);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({flush_cnt, stall_cnt, fwd_a, fwd_b} !== {32'd1, 32'd1, 4'b1010})
      $display("FAIL freeze_hold: got flush=%0d stall=%0d fwd=%0d/%0d required 1 1 2/2",
               flush_cnt, stall_cnt, fwd_a, fwd_b);
    else n_pass++;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 5'b11111) $display("FAIL unfreeze_flush: got %b required %b", ctrl, 5'b11111);
    else n_pass++;
    step();
    ex_br_taken = 1'b0;
    step();
    n_checks++;
    if (flush_cnt !== 32'd2) $display("FAIL unfreeze_cnt: got %0d required 2", flush_cnt);
    else n_pass++;
    mem_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({flush_cnt, stall_cnt, fwd_a, fwd_b, ctrl} !== {68'd0, 5'b11001})
      $display("FAIL reset_in_freeze: got cnt=%0d/%0d fwd=%0d/%0d ctrl=%b required 0 0 0 0 11001",
               flush_cnt, stall_cnt, fwd_a, fwd_b, ctrl);
    else n_pass++;
    set_idle();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_x0();
    test_load_use();
    test_stall_only();
    test_saturate();
    test_branch_load_use();
    test_freeze_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
